// File: rtl/mem_bus_arbiter.sv
// N-master request/grant arbiter for the shared CPU memory bus.
// Fixed-priority or round-robin selection, bus lock and bounded hold time.
module mem_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int RR_MODE     = 0,
  parameter int MAX_HOLD    = 0,
  parameter int HOLD_W      = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_MASTERS-1:0]        req_in,
  input  logic [NUM_MASTERS-1:0]        lock_in,
  input  logic [NUM_MASTERS*ADDR_W-1:0] a_in,
  input  logic [NUM_MASTERS-1:0]        r_nw_in,
  input  logic [NUM_MASTERS*DATA_W-1:0] d_in,
  input  logic [DATA_W-1:0]             bus_d_in,
  output logic [NUM_MASTERS-1:0]        gnt_out,
  output logic [NUM_MASTERS-1:0]        rdy_out,
  output logic [ADDR_W-1:0]             a_out,
  output logic                          r_nw_out,
  output logic [DATA_W-1:0]             d_out,
  output logic [DATA_W-1:0]             rd_d_out
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_MASTERS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM =
    (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
  localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN    = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  owner, owner_n;
  logic [IDX_W-1:0]  last_owner, last_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [IDX_W-1:0]  sel;
  logic              sel_vld;
  logic [NUM_MASTERS-1:0] own_oh;
  logic [NUM_MASTERS-1:0] others;
  logic              preempt;

  // Candidate owner: lowest index, or first requester after the last owner
  always_comb begin
    int c;
    c       = 0;
    sel     = '0;
    sel_vld = 1'b0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (RR_MODE != 0) begin
        c = int'(last_owner) + 1 + j;
        if (c >= NUM_MASTERS) c = c - NUM_MASTERS;
      end else begin
        c = j;
      end
      if (!sel_vld && req_in[c]) begin
        sel_vld = 1'b1;
        sel     = IDX_W'(c);
      end
    end
  end

  assign own_oh  = NUM_MASTERS'(1) << owner;
  assign others  = req_in & ~own_oh;
  assign preempt = (MAX_HOLD > 0) && (hold_cnt >= HOLD_LIM) &&
                   !lock_in[owner] && (|others);

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= LAST_INIT;
      hold_cnt   <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_n;
      hold_cnt   <= hold_n;
    end
  end

  // Next-state: grant, release, preemption and the dead handover cycle
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last_owner;
    hold_n  = hold_cnt;
    unique case (state)
      IDLE, SWITCH: begin
        if (sel_vld) begin
          state_n = OWN;
          owner_n = sel;
          last_n  = sel;
          hold_n  = '0;
        end else begin
          state_n = IDLE;
        end
      end
      OWN: begin
        if (!req_in[owner]) begin
          state_n = (|others) ? SWITCH : IDLE;
        end else if (preempt) begin
          state_n = SWITCH;
        end else if (hold_cnt != HOLD_SAT) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bus steering: owner's signals, otherwise a harmless read of address 0
  always_comb begin
    gnt_out  = '0;
    a_out    = '0;
    r_nw_out = 1'b1;
    d_out    = '0;
    if (state == OWN) begin
      gnt_out  = own_oh;
      a_out    = a_in[owner*ADDR_W +: ADDR_W];
      r_nw_out = r_nw_in[owner];
      d_out    = d_in[owner*DATA_W +: DATA_W];
    end
  end

  assign rdy_out  = gnt_out;
  assign rd_d_out = bus_d_in;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a 2-master fixed-priority instance and a
// 4-master round-robin instance, checked against a cycle model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, lock, rnw;
  logic [63:0] a;
  logic [31:0] d;
  logic [7:0]  bd;

  logic [1:0]  gnt0, rdy0;
  logic [15:0] ao0;
  logic        rnwo0;
  logic [7:0]  do0, rd0;
  logic [3:0]  gnt1, rdy1;
  logic [15:0] ao1;
  logic        rnwo1;
  logic [7:0]  do1, rd1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .NUM_MASTERS(2), .ADDR_W(16), .DATA_W(8),
    .RR_MODE(0), .MAX_HOLD(2), .HOLD_W(8)
  ) u_fp (
    .clk_in(clk), .rst_in(rst),
    .req_in(req[1:0]), .lock_in(lock[1:0]),
    .a_in(a[31:0]), .r_nw_in(rnw[1:0]), .d_in(d[15:0]),
    .bus_d_in(bd),
    .gnt_out(gnt0), .rdy_out(rdy0), .a_out(ao0),
    .r_nw_out(rnwo0), .d_out(do0), .rd_d_out(rd0)
  );

  mem_bus_arbiter #(
    .NUM_MASTERS(4), .ADDR_W(16), .DATA_W(8),
    .RR_MODE(1), .MAX_HOLD(3), .HOLD_W(8)
  ) u_rr (
    .clk_in(clk), .rst_in(rst),
    .req_in(req), .lock_in(lock),
    .a_in(a), .r_nw_in(rnw), .d_in(d),
    .bus_d_in(bd),
    .gnt_out(gnt1), .rdy_out(rdy1), .a_out(ao1),
    .r_nw_out(rnwo1), .d_out(do1), .rd_d_out(rd1)
  );

  // Model: owner index (-1 = nobody), dead-cycle flag, cycles owned so far
  int nm[2] = '{2, 4};
  int rr[2] = '{0, 1};
  int mh[2] = '{2, 3};
  int own[2]  = '{-1, -1};
  int sw[2]   = '{0, 0};
  int held[2] = '{0, 0};
  int last[2] = '{1, 3};
  int rr_order[$];

  function automatic int pick(int id);
    int idx;
    for (int j = 0; j < nm[id]; j++) begin
      idx = rr[id] ? (last[id] + 1 + j) % nm[id] : j;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit rivals(int id);
    for (int i = 0; i < nm[id]; i++)
      if (i != own[id] && req[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(int id);
    int p;
    if (rst) begin
      own[id] = -1; sw[id] = 0; held[id] = 0;
      last[id] = nm[id] - 1;
    end else if (own[id] < 0) begin
      sw[id] = 0;
      p = pick(id);
      if (p >= 0) begin
        own[id] = p; held[id] = 1; last[id] = p;
        if (id == 1) rr_order.push_back(p);
      end
    end else if (!req[own[id]]) begin
      sw[id] = rivals(id);
      own[id] = -1;
    end else if (held[id] >= mh[id] && !lock[own[id]] && rivals(id)) begin
      sw[id] = 1;
      own[id] = -1;
    end else begin
      held[id]++;
    end
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int o;
    logic [3:0]  eg;
    logic [15:0] ea;
    logic        er;
    logic [7:0]  ed;
    for (int id = 0; id < 2; id++) begin
      o  = own[id];
      eg = (o >= 0) ? 4'(1 << o) : 4'd0;
      ea = (o >= 0) ? a[o*16 +: 16] : 16'h0;
      er = (o >= 0) ? rnw[o] : 1'b1;
      ed = (o >= 0) ? d[o*8 +: 8] : 8'h0;
      if (id == 0) begin
        check("fp_gnt", 64'(gnt0), 64'(eg));
        check("fp_rdy", 64'(rdy0), 64'(eg));
        check("fp_a", 64'(ao0), 64'(ea));
        check("fp_rnw", 64'(rnwo0), 64'(er));
        check("fp_d", 64'(do0), 64'(ed));
        check("fp_rd", 64'(rd0), 64'(bd));
      end else begin
        check("rr_gnt", 64'(gnt1), 64'(eg));
        check("rr_rdy", 64'(rdy1), 64'(eg));
        check("rr_a", 64'(ao1), 64'(ea));
        check("rr_rnw", 64'(rnwo1), 64'(er));
        check("rr_d", 64'(do1), 64'(ed));
        check("rr_rd", 64'(rd1), 64'(bd));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic randomize_bus();
    a  = {$urandom, $urandom};
    d  = $urandom;
    bd = 8'($urandom);
  endtask

  initial begin
    int n;
    rst = 1'b1; req = 4'b0011; lock = '0; rnw = '1;
    a = '0; d = '0; bd = 8'h00;
    @(negedge clk);
    cycle();
    check("rst_gnt", 64'(gnt0), 64'd0);
    check("rst_a", 64'(ao0), 64'd0);
    check("rst_rnw", 64'(rnwo0), 64'd1);
    rst = 1'b0;
    cycle();
    check("first_gnt", 64'(gnt0), 64'b01);

    // Master 1 writes, master 0 waits behind it until req1 drops
    rst = 1'b1; req = 4'b0010; lock = 4'b0010; rnw = 4'b1101;
    a[31:16] = 16'h2006; d[15:8] = 8'h3F;
    cycle();
    rst = 1'b0;
    cycle();
    req = 4'b0011;
    for (int i = 0; i < 4; i++) cycle();
    check("fp_hold_a", 64'(ao0), 64'h2006);
    check("fp_hold_d", 64'(do0), 64'h3F);
    req = 4'b0001; lock = '0;
    cycle();
    check("fp_sw_gnt", 64'(gnt0), 64'd0);
    check("fp_sw_rnw", 64'(rnwo0), 64'd1);
    cycle();
    check("fp_new_gnt", 64'(gnt0), 64'b01);

    // Round robin rotation with everyone requesting
    rst = 1'b1; req = 4'b1111; lock = '0;
    cycle();
    rst = 1'b0;
    rr_order.delete();
    for (int i = 0; i < 18; i++) cycle();
    n = rr_order.size();
    check("rr_count", 64'(n), 64'd5);
    for (int i = 0; i < 5 && i < n; i++)
      check("rr_order", 64'(rr_order[i]), 64'(i % 4));

    // Request withdrawn during the dead cycle: straight to idle
    rst = 1'b1; req = 4'b0001;
    cycle();
    rst = 1'b0;
    cycle();
    req = 4'b0010;
    cycle();
    check("wd_sw", 64'(gnt0), 64'd0);
    req = 4'b0000;
    cycle();
    check("wd_idle", 64'(gnt0), 64'd0);
    cycle();
    check("wd_stay", 64'(gnt0), 64'd0);

    // Reset during a write
    req = 4'b0001; rnw = 4'b1110; a[15:0] = 16'h1234;
    cycle();
    check("mw_rnw0", 64'(rnwo0), 64'd0);
    rst = 1'b1;
    cycle();
    check("mw_rnw1", 64'(rnwo0), 64'd1);
    check("mw_a", 64'(ao0), 64'd0);
    rst = 1'b0;

    // Random traffic: sticky requests, occasional locks and resets
    for (int i = 0; i < 800; i++) begin
      for (int m = 0; m < 4; m++) begin
        if ($urandom_range(4, 0) == 0) req[m] = ~req[m];
        lock[m] = ($urandom_range(5, 0) == 0);
      end
      rnw = 4'($urandom);
      rst = ($urandom_range(150, 0) == 0);
      randomize_bus();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
